lock_input_conditioner: RTL and testbench
=========================================

# lock_input_conditioner

Upstream front end for the airlock interlock controller: takes the raw board push-buttons and slide switches, synchronizes and debounces each one, and presents the controller with clean single-cycle command pulses (arrive, depart, fill, drain) and stable port-position levels (iport, oport). It also rejects simultaneous commands and flags the physically illegal "both ports open" condition. The controller consumes its outputs directly; no other glue sits between them.

## Interface
Parameters:
- SYNC_STAGES, 2: synchronizer flops per input, minimum 2.
- DEBOUNCE_CYCLES, 50000: consecutive cycles a new synchronized level must hold before it is accepted (1 ms at 50 MHz).
- CNT_W, 16: debounce counter width; must satisfy 2^CNT_W > DEBOUNCE_CYCLES.

Ports (one clock; reset is synchronous and active-low):
- clock  in  1  system clock, all logic on rising edge.
- reset  in  1  synchronous active-low reset, sampled on rising edge of clock.
- key_arrive, key_depart, key_fill, key_drain  in  1 each  raw push-buttons, active-low (0 = pressed), asynchronous to clock.
- sw_iport, sw_oport  in  1 each  raw slide switches, active-high (1 = port open), asynchronous.
- arrive, depart, fill, drain  out  1 each  registered one-cycle command pulses.
- iport, oport  out  1 each  registered debounced port levels, 1 = open.
- cmd_conflict  out  1  registered one-cycle pulse: two or more commands qualified in the same cycle.
- port_fault  out  1  registered level: iport and oport both 1.

## Operation
- Six identical channels. Each: SYNC_STAGES-flop synchronizer, then key inputs inverted to active-high, then a debounce stage holding a `stable` bit and a CNT_W counter.
- Debounce per cycle: if sync == stable, counter <= 0. Else if counter == DEBOUNCE_CYCLES-1, stable <= sync and counter <= 0. Else counter <= counter + 1. A disagreement shorter than DEBOUNCE_CYCLES cycles never changes `stable`; any return to agreement restarts the count from 0.
- iport/oport = stable of their channels.
- Command qualification: a command channel qualifies on the cycle its stable bit goes 0->1 (press). Release (1->0) produces nothing.
- Arbitration: exactly one qualified command -> that pulse high for one cycle. Two or more qualified in the same cycle -> all four command pulses stay 0, cmd_conflict high for one cycle. Holding a key never re-pulses; a new pulse needs release then press, each debounced.
- port_fault = iport & oport, updated in the same cycle as those outputs.
- Reset (reset == 0 at an edge): all synchronizer flops to the inactive level (keys 1, switches 0), all stable bits 0, counters 0, every output 0. Reset mid-debounce discards the partial count. A key held through reset release is treated as a new press and pulses once after the normal latency.

## Timing
- Let raw input change and remain constant from before edge E0. Synchronized value reflects it after edge E0+SYNC_STAGES-1. Stable/level output changes at edge E0+SYNC_STAGES-1+DEBOUNCE_CYCLES; the command pulse (or cmd_conflict) is high in the cycle following that same edge, for exactly one cycle.
- With SYNC_STAGES=2, DEBOUNCE_CYCLES=4: latency E0+5.
- port_fault has the same latency as the later of iport/oport.
- No combinational path from any input to any output.

## Test plan
Bench uses SYNC_STAGES=2, DEBOUNCE_CYCLES=4.
- Reset: hold reset=0 for 3 edges with all keys pressed and both switches 1 -> all outputs 0 throughout; after release, cmd_conflict pulses once at E0+5, iport=oport=port_fault=1 from E0+5.
- Clean press: key_fill 1->0 before E0, held 20 cycles -> fill high exactly one cycle after E0+5, no other pulse; release and re-press -> second single pulse.
- Glitch rejection: key_drain low for 3 cycles then high, repeated 5 times -> drain never asserts; counter returns to 0 each time.
- Simultaneous: key_arrive and key_depart pressed at same E0 -> arrive=depart=0, cmd_conflict one cycle at E0+5; pressed 1 cycle apart -> arrive pulse then depart pulse, no conflict.
- Ports: sw_iport 0->1 at E0, sw_oport 0->1 at E0+10 -> iport=1 from E0+5, oport=1 and port_fault=1 from E0+15; sw_iport->0 at E0+20 -> port_fault=0 from E0+25.
- Reset mid-debounce: key_arrive pressed at E0, reset=0 at E0+3 for one edge, then released reset -> no pulse before E0+4+5; exactly one arrive pulse after full latency from reset release.

Source files
------------

// File: rtl/lock_input_conditioner.sv
// Airlock front end: synchronizes and debounces six raw board inputs, turns key
// presses into arbitrated single-cycle command pulses and flags both ports open.
module lock_input_conditioner #(
  parameter int SYNC_STAGES     = 2,
  parameter int DEBOUNCE_CYCLES = 50000,
  parameter int CNT_W           = 16
) (
  input  logic clock,
  input  logic reset,
  input  logic key_arrive,
  input  logic key_depart,
  input  logic key_fill,
  input  logic key_drain,
  input  logic sw_iport,
  input  logic sw_oport,
  output logic arrive,
  output logic depart,
  output logic fill,
  output logic drain,
  output logic iport,
  output logic oport,
  output logic cmd_conflict,
  output logic port_fault
);

  localparam int NCH = 6;
  // Channels 0-3 are active-low keys, 4-5 active-high switches.
  localparam logic [NCH-1:0] ACT_LOW = 6'b00_1111;
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic [NCH-1:0] raw;
  logic [NCH-1:0] stable_q, stable_d;

  assign raw = {sw_oport, sw_iport, key_drain, key_fill, key_depart, key_arrive};

  for (genvar gi = 0; gi < NCH; gi++) begin : g_ch
    logic [SYNC_STAGES-1:0] sync_q, sync_d;
    logic [CNT_W-1:0]       cnt_q, cnt_d;
    logic                   st_q, st_d;
    logic                   lvl;

    assign lvl = sync_q[SYNC_STAGES-1] ^ ACT_LOW[gi];

    always_comb begin
      sync_d = {sync_q[SYNC_STAGES-2:0], raw[gi]};
      st_d   = st_q;
      cnt_d  = cnt_q;
      if (lvl == st_q) begin
        cnt_d = '0;
      end else if (cnt_q == CNT_MAX) begin
        st_d  = lvl;
        cnt_d = '0;
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end

    always_ff @(posedge clock) begin
      if (!reset) begin
        sync_q <= {SYNC_STAGES{ACT_LOW[gi]}};
        st_q   <= 1'b0;
        cnt_q  <= '0;
      end else begin
        sync_q <= sync_d;
        st_q   <= st_d;
        cnt_q  <= cnt_d;
      end
    end

    assign stable_q[gi] = st_q;
    assign stable_d[gi] = st_d;
  end

  logic [3:0] rise;
  logic       multi;
  logic [3:0] cmd_q, cmd_d;
  logic       conflict_q, conflict_d;
  logic       fault_q, fault_d;

  // Qualify on the next-state edge so the pulse registers with the level change.
  always_comb begin
    rise       = stable_d[3:0] & ~stable_q[3:0];
    multi      = |(rise & (rise - 4'd1));
    cmd_d      = multi ? 4'b0000 : rise;
    conflict_d = multi;
    fault_d    = stable_d[4] & stable_d[5];
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      cmd_q      <= 4'b0000;
      conflict_q <= 1'b0;
      fault_q    <= 1'b0;
    end else begin
      cmd_q      <= cmd_d;
      conflict_q <= conflict_d;
      fault_q    <= fault_d;
    end
  end

  assign arrive       = cmd_q[0];
  assign depart       = cmd_q[1];
  assign fill         = cmd_q[2];
  assign drain        = cmd_q[3];
  assign cmd_conflict = conflict_q;
  assign iport        = stable_q[4];
  assign oport        = stable_q[5];
  assign port_fault   = fault_q;

endmodule

// File: tb/tb_lock_input_conditioner.sv
// Directed bench for lock_input_conditioner with SYNC_STAGES=2, DEBOUNCE_CYCLES=4
// (input change before edge E0 shows at the outputs after edge E0+5).
module tb_lock_input_conditioner;

  logic clock = 1'b0;
  logic reset;
  logic key_arrive, key_depart, key_fill, key_drain;
  logic sw_iport, sw_oport;
  logic arrive, depart, fill, drain, iport, oport, cmd_conflict, port_fault;

  int n_total = 0;
  int n_pass  = 0;

  lock_input_conditioner #(
    .SYNC_STAGES(2),
    .DEBOUNCE_CYCLES(4),
    .CNT_W(16)
  ) dut (
    .clock(clock),
    .reset(reset),
    .key_arrive(key_arrive),
    .key_depart(key_depart),
    .key_fill(key_fill),
    .key_drain(key_drain),
    .sw_iport(sw_iport),
    .sw_oport(sw_oport),
    .arrive(arrive),
    .depart(depart),
    .fill(fill),
    .drain(drain),
    .iport(iport),
    .oport(oport),
    .cmd_conflict(cmd_conflict),
    .port_fault(port_fault)
  );

  always #5 clock = ~clock;

  // Output vector: {arrive, depart, fill, drain, cmd_conflict, iport, oport, port_fault}
  function automatic logic [7:0] outs();
    return {arrive, depart, fill, drain, cmd_conflict, iport, oport, port_fault};
  endfunction

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  // n cycles; tick i (1-based) expects pre before 'at', hit at 'at', post after.
  task automatic run(input string tag, input int n, input int at,
                     input logic [7:0] pre, input logic [7:0] hit, input logic [7:0] post);
    logic [7:0] exp;
    logic [7:0] obs;
    for (int i = 1; i <= n; i++) begin
      tick();
      exp = (i < at) ? pre : ((i == at) ? hit : post);
      obs = outs();
      n_total++;
      assert (obs === exp) n_pass++;
      else $error("FAIL %s cycle %0d: observed %b expected %b", tag, i, obs, exp);
      $display("check %s cycle %0d: outs=%b exp=%b", tag, i, obs, exp);
    end
  endtask

  initial begin
    reset = 1'b0;
    key_arrive = 1'b0; key_depart = 1'b0; key_fill = 1'b0; key_drain = 1'b0;
    sw_iport = 1'b1;   sw_oport = 1'b1;
    run("rst_hold", 3, 99, 8'h00, 8'h00, 8'h00);
    reset = 1'b1;
    run("rst_release", 10, 6, 8'h00, 8'h0F, 8'h07);
    key_arrive = 1'b1; key_depart = 1'b1; key_fill = 1'b1; key_drain = 1'b1;
    sw_iport = 1'b0;   sw_oport = 1'b0;
    run("rst_clear", 10, 6, 8'h07, 8'h00, 8'h00);

    key_fill = 1'b0;
    run("fill_press1", 20, 6, 8'h00, 8'h20, 8'h00);
    key_fill = 1'b1;
    run("fill_release", 8, 99, 8'h00, 8'h00, 8'h00);
    key_fill = 1'b0;
    run("fill_press2", 10, 6, 8'h00, 8'h20, 8'h00);
    key_fill = 1'b1;
    run("fill_release2", 8, 99, 8'h00, 8'h00, 8'h00);

    repeat (5) begin
      key_drain = 1'b0;
      run("drain_glitch_lo", 3, 99, 8'h00, 8'h00, 8'h00);
      key_drain = 1'b1;
      run("drain_glitch_hi", 3, 99, 8'h00, 8'h00, 8'h00);
    end
    run("drain_glitch_tail", 6, 99, 8'h00, 8'h00, 8'h00);
    key_drain = 1'b0;
    run("drain_min_lo", 4, 99, 8'h00, 8'h00, 8'h00);
    key_drain = 1'b1;
    run("drain_min_hit", 10, 2, 8'h00, 8'h10, 8'h00);

    key_arrive = 1'b0; key_depart = 1'b0;
    run("simul", 10, 6, 8'h00, 8'h08, 8'h00);
    key_arrive = 1'b1; key_depart = 1'b1;
    run("simul_release", 8, 99, 8'h00, 8'h00, 8'h00);
    key_arrive = 1'b0;
    run("stagger_a0", 1, 99, 8'h00, 8'h00, 8'h00);
    key_depart = 1'b0;
    run("stagger_wait", 4, 99, 8'h00, 8'h00, 8'h00);
    run("stagger_arrive", 1, 1, 8'h00, 8'h80, 8'h00);
    run("stagger_depart", 1, 1, 8'h00, 8'h40, 8'h00);
    run("stagger_after", 6, 99, 8'h00, 8'h00, 8'h00);
    key_arrive = 1'b1; key_depart = 1'b1;
    run("stagger_release", 8, 99, 8'h00, 8'h00, 8'h00);

    sw_iport = 1'b1;
    run("iport_open", 10, 6, 8'h00, 8'h04, 8'h04);
    sw_oport = 1'b1;
    run("oport_open", 10, 6, 8'h04, 8'h07, 8'h07);
    sw_iport = 1'b0;
    run("iport_close", 10, 6, 8'h07, 8'h02, 8'h02);
    sw_oport = 1'b0;
    run("oport_close", 10, 6, 8'h02, 8'h00, 8'h00);

    key_arrive = 1'b0;
    run("mid_pre", 3, 99, 8'h00, 8'h00, 8'h00);
    reset = 1'b0;
    run("mid_reset", 1, 99, 8'h00, 8'h00, 8'h00);
    reset = 1'b1;
    run("mid_after", 10, 6, 8'h00, 8'h80, 8'h00);
    key_arrive = 1'b1;
    run("mid_release", 8, 99, 8'h00, 8'h00, 8'h00);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
